// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - EX forwarding select codes, 2-slot scoreboard and load-wait stall FSM
module hazard_ctrl #(
    parameter int RA_W     = 5,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_rd_wen,
    input  logic            id_is_load,
    input  logic            id_is_store,
    input  logic            ex_flush,
    input  logic            dmem_rvalid,
    output logic [1:0]      rs1_hazard,
    output logic [1:0]      rs2_hazard,
    output logic            store_load_hazard,
    output logic            stall,
    output logic            load_timeout
);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;

    // EX slot keeps the full record; WB only needs valid/load to drive the stall.
    logic            ex_v;
    logic [RA_W-1:0] ex_rd;
    logic            ex_wen;
    logic            ex_ld;
    logic            wb_v;
    logic            wb_ld;

    logic id_live;
    logic rs1_match;
    logic rs2_match;
    logic load_pending;
    logic at_limit;
    logic timeout_now;

    assign id_live      = id_valid & ~ex_flush;
    assign rs1_match    = id_rs1_used & (id_rs1 != '0) & ex_v & ex_wen & (ex_rd == id_rs1);
    assign rs2_match    = id_rs2_used & (id_rs2 != '0) & ex_v & ex_wen & (ex_rd == id_rs2);
    assign load_pending = wb_v & wb_ld & ~dmem_rvalid;
    assign at_limit     = (state == S_WAIT) && (cnt == CNT_W'(WAIT_MAX));
    assign timeout_now  = load_pending & at_limit;
    // Released on the timeout cycle so the pipe advances while the load is dropped.
    assign stall        = load_pending & ~at_limit;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state             <= S_RUN;
            cnt               <= '0;
            ex_v              <= 1'b0;
            ex_rd             <= '0;
            ex_wen            <= 1'b0;
            ex_ld             <= 1'b0;
            wb_v              <= 1'b0;
            wb_ld             <= 1'b0;
            rs1_hazard        <= 2'b00;
            rs2_hazard        <= 2'b00;
            store_load_hazard <= 1'b0;
            load_timeout      <= 1'b0;
        end else begin
            load_timeout <= 1'b0;
            case (state)
                S_RUN: begin
                    if (load_pending) begin
                        state <= S_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end else if (at_limit) begin
                        state        <= S_RUN;
                        cnt          <= '0;
                        load_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
            endcase

            if (!stall) begin
                wb_v   <= ex_v & ~timeout_now;
                wb_ld  <= ex_ld;
                ex_v   <= id_live;
                ex_rd  <= id_rd;
                ex_wen <= id_rd_wen;
                ex_ld  <= id_is_load;

                rs1_hazard        <= (id_live & rs1_match) ? (ex_ld ? 2'b10 : 2'b01) : 2'b00;
                rs2_hazard        <= (id_live & rs2_match) ? (ex_ld ? 2'b10 : 2'b01) : 2'b00;
                store_load_hazard <= id_live & id_is_store & rs2_match & ex_ld;
            end
        end
    end

endmodule
